// File: rtl/grf_dump.sv
// grf_dump: walks the GRF read port from START_ADDR to END_ADDR and streams {address, value} beats.
// Optional feature: define GRF_DUMP_SKIPZERO_EN to suppress beats for registers that read as zero.
module grf_dump #(
  parameter int START_ADDR = 0,
  parameter int END_ADDR   = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [4:0]  grf_a,
  input  logic [31:0] grf_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_addr,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] START_IDX = 5'(START_ADDR);
  localparam logic [4:0] END_IDX   = 5'(END_ADDR);

`ifdef GRF_DUMP_SKIPZERO_EN
  localparam bit SKIP_ZERO = 1'b1;
`else
  localparam bit SKIP_ZERO = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, READ, HOLD, DONE} state_t;

  state_t     state;
  logic [4:0] idx;

  assign grf_a = idx;

  // Scan FSM; the value is captured at the READ edge, so a same-edge GRF write is not seen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= START_IDX;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            idx   <= START_IDX;
            busy  <= 1'b1;
            state <= READ;
          end
        end
        READ: begin
          if (SKIP_ZERO && grf_rd == 32'd0) begin
            if (idx == END_IDX) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx <= idx + 5'd1;
            end
          end else begin
            out_data  <= grf_rd;
            out_addr  <= idx;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (idx == END_IDX) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx   <= idx + 5'd1;
              state <= READ;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grf_dump.sv
// tb_grf_dump: directed scenarios for grf_dump against a small GRF model and a per-cycle expected schedule.
module tb_grf_dump;

  localparam int MAXC = 128;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  grf_a;
  logic [31:0] grf_rd;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic        busy;
  logic        done;

  logic [31:0] regs [32];
  logic [31:0] load_img [32];
  logic        load_now;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int stall_beat;
    int stall_len;
    int restart_cycle;
    int wr_cycle;
    int stop_cycle;
    bit sparse;
  } scen_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          valid_cycle;
    int          hold_len;
  } beat_t;

  beat_t beats [32];
  bit          exp_valid [MAXC];
  bit          exp_busy [MAXC];
  bit          exp_done [MAXC];
  logic [4:0]  exp_addr [MAXC];
  logic [31:0] exp_data [MAXC];

  grf_dump #(.START_ADDR(0), .END_ADDR(31)) dut (
    .clk(clk), .reset(reset), .start(start), .grf_a(grf_a), .grf_rd(grf_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .busy(busy), .done(done)
  );

  initial forever #5 clk = ~clk;

  // GRF model: combinational read, writes land after the edge like the real register file
  always_comb grf_rd = regs[grf_a];

  always @(posedge clk) begin
    if (load_now) regs <= load_img;
    else if (wr_en && wr_addr != 5'd0) regs[wr_addr] <= wr_data;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic loadImage(input bit sparse);
    for (int i = 0; i < 32; i++) load_img[i] = sparse ? 32'd0 : 32'h01010101 * i;
    if (sparse) begin
      load_img[8]  = 32'h5;
      load_img[31] = 32'hFFFFFFFF;
    end
    @(negedge clk);
    load_now = 1'b1;
    @(negedge clk);
    load_now = 1'b0;
  endtask

  task automatic applyStimulus(input scen_t sc);
    int t = 1;
    int nb = 0;
    int done_cycle;
    int stall;
    int vc;
    for (int c = 0; c < MAXC; c++) begin
      exp_valid[c] = 1'b0;
      exp_busy[c]  = 1'b0;
      exp_done[c]  = 1'b0;
      exp_addr[c]  = '0;
      exp_data[c]  = '0;
    end
    // Expected timeline: emitted register costs 2 cycles plus stalls, skipped register 1 cycle
    for (int a = 0; a < 32; a++) begin
`ifdef GRF_DUMP_SKIPZERO_EN
      if (load_img[a] == 32'd0) begin
        t++;
        continue;
      end
`endif
      stall = (nb == sc.stall_beat) ? sc.stall_len : 0;
      beats[nb] = '{addr: 5'(a), data: load_img[a], valid_cycle: t + 1, hold_len: 1 + stall};
      nb++;
      t += 2 + stall;
    end
    done_cycle = t;
    for (int c = 1; c < done_cycle; c++) exp_busy[c] = 1'b1;
    exp_done[done_cycle] = 1'b1;
    for (int b = 0; b < nb; b++)
      for (int c = beats[b].valid_cycle; c < beats[b].valid_cycle + beats[b].hold_len; c++) begin
        exp_valid[c] = 1'b1;
        exp_addr[c]  = beats[b].addr;
        exp_data[c]  = beats[b].data;
      end

    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b1;
    for (int c = 1; c <= done_cycle + 1; c++) begin
      @(negedge clk);
      checkOutput($sformatf("out_valid c%0d", c), 32'(out_valid), 32'(exp_valid[c]));
      checkOutput($sformatf("busy c%0d", c), 32'(busy), 32'(exp_busy[c]));
      checkOutput($sformatf("done c%0d", c), 32'(done), 32'(exp_done[c]));
      if (exp_valid[c]) begin
        checkOutput($sformatf("out_addr c%0d", c), 32'(out_addr), 32'(exp_addr[c]));
        checkOutput($sformatf("out_data c%0d", c), out_data, exp_data[c]);
      end
      start = (c == sc.restart_cycle);
      wr_en = (c == sc.wr_cycle);
      out_ready = 1'b1;
      if (sc.stall_beat >= 0 && sc.stall_beat < nb) begin
        vc = beats[sc.stall_beat].valid_cycle;
        if (c >= vc && c < vc + sc.stall_len) out_ready = 1'b0;
      end
      if (c == sc.stop_cycle) return;
    end
  endtask

  scen_t scens [7];

  initial begin
    reset = 1'b0;
    start = 1'b0;
    out_ready = 1'b1;
    load_now = 1'b0;
    wr_en = 1'b0;
    wr_addr = 5'd5;
    wr_data = 32'hDEADBEEF;

    scens[0] = '{stall_beat: -1, stall_len: 0, restart_cycle: 0,  wr_cycle: 0,  stop_cycle: 0,  sparse: 1'b0};
    scens[1] = '{stall_beat: 3,  stall_len: 5, restart_cycle: 0,  wr_cycle: 0,  stop_cycle: 0,  sparse: 1'b0};
    scens[2] = '{stall_beat: -1, stall_len: 0, restart_cycle: 10, wr_cycle: 0,  stop_cycle: 0,  sparse: 1'b0};
    scens[3] = '{stall_beat: -1, stall_len: 0, restart_cycle: 0,  wr_cycle: 11, stop_cycle: 0,  sparse: 1'b0};
    scens[4] = '{stall_beat: -1, stall_len: 0, restart_cycle: 0,  wr_cycle: 0,  stop_cycle: 22, sparse: 1'b0};
    scens[5] = '{stall_beat: -1, stall_len: 0, restart_cycle: 0,  wr_cycle: 0,  stop_cycle: 0,  sparse: 1'b0};
    scens[6] = '{stall_beat: -1, stall_len: 0, restart_cycle: 0,  wr_cycle: 0,  stop_cycle: 0,  sparse: 1'b1};

    repeat (2) @(negedge clk);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset out_addr", 32'(out_addr), 32'd0);
    checkOutput("reset out_data", out_data, 32'd0);
    checkOutput("reset grf_a", 32'(grf_a), 32'd0);
    reset = 1'b1;

    for (int s = 0; s < 7; s++) begin
      $display("[TB] scenario %0d", s);
      loadImage(scens[s].sparse);
      applyStimulus(scens[s]);
      if (scens[s].stop_cycle != 0) begin
        // Asynchronous reset while beat 10 is held; outputs must clear before the next edge
        #1 reset = 1'b0;
        #1;
        checkOutput("async out_valid", 32'(out_valid), 32'd0);
        checkOutput("async out_addr", 32'(out_addr), 32'd0);
        checkOutput("async out_data", out_data, 32'd0);
        checkOutput("async busy", 32'(busy), 32'd0);
        checkOutput("async done", 32'(done), 32'd0);
        checkOutput("async grf_a", 32'(grf_a), 32'd0);
        @(negedge clk);
        reset = 1'b1;
      end
      wr_en = 1'b0;
      start = 1'b0;
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
